// File: rtl/matrix_stream_writer.sv
// Walks a ROWS x COLS result buffer in row- or column-major order and
// streams each element out over valid/ready with line/matrix end markers.
module matrix_stream_writer #(
    parameter int ROWS   = 8,
    parameter int COLS   = 8,
    parameter int DW     = 32,
    parameter int RD_LAT = 1,
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          col_major,
    output logic          rd_en,
    output logic [RW-1:0] rd_row,
    output logic [CW-1:0] rd_col,
    input  logic [DW-1:0] rd_data,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_last_line,
    output logic          out_last,
    output logic          busy,
    output logic          done
);

    localparam int LW = $clog2(RD_LAT + 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);
    localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);
    localparam logic [LW-1:0] LAT_INIT = LW'(RD_LAT);
    localparam logic [LW-1:0] LAT_ONE = LW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_SEND,
        S_DONE
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic          mode_q;
    logic [RW-1:0] row_q;
    logic [CW-1:0] col_q;
    logic [LW-1:0] lat_q;
    logic          row_end;
    logic          col_end;
    logic          hs;

    assign row_end = (row_q == ROW_MAX);
    assign col_end = (col_q == COL_MAX);
    assign hs      = (state_q == S_SEND) && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_READ;
                end
            end
            S_READ: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (lat_q == LAT_ONE) begin
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (out_ready) begin
                    state_d = out_last ? S_DONE : S_READ;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // The counters double as the read address; they only move on a
    // handshake, so the address holds steady outside READ.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q        <= 1'b0;
            row_q         <= '0;
            col_q         <= '0;
            lat_q         <= '0;
            out_data      <= '0;
            out_last_line <= 1'b0;
            out_last      <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        mode_q <= col_major;
                        row_q  <= '0;
                        col_q  <= '0;
                    end
                end
                S_READ: begin
                    lat_q <= LAT_INIT;
                end
                S_WAIT: begin
                    lat_q <= lat_q - LAT_ONE;
                    if (lat_q == LAT_ONE) begin
                        out_data      <= rd_data;
                        out_last_line <= mode_q ? row_end : col_end;
                        out_last      <= row_end && col_end;
                    end
                end
                S_SEND: begin
                    if (hs && !out_last) begin
                        if (!mode_q) begin
                            if (col_end) begin
                                col_q <= '0;
                                row_q <= row_q + RW'(1);
                            end else begin
                                col_q <= col_q + CW'(1);
                            end
                        end else begin
                            if (row_end) begin
                                row_q <= '0;
                                col_q <= col_q + CW'(1);
                            end else begin
                                row_q <= row_q + RW'(1);
                            end
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign rd_en     = (state_q == S_READ);
    assign rd_row    = row_q;
    assign rd_col    = col_q;
    assign out_valid = (state_q == S_SEND);
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_matrix_stream_writer.sv
// Directed bench: a 2x3 writer (read latency 1) and a 1x1 writer
// (read latency 3) against simple buffer models.
module tb_matrix_stream_writer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        start_a = 1'b0;
    logic        cm_a = 1'b0;
    logic        rd_en_a;
    logic [0:0]  rd_row_a;
    logic [1:0]  rd_col_a;
    logic [31:0] rd_data_a = '0;
    logic [31:0] out_data_a;
    logic        out_valid_a;
    logic        out_ready_a = 1'b1;
    logic        ll_a;
    logic        last_a;
    logic        busy_a;
    logic        done_a;

    logic        start_b = 1'b0;
    logic        rd_en_b;
    logic [0:0]  rd_row_b;
    logic [0:0]  rd_col_b;
    logic [31:0] rd_data_b = '0;
    logic [31:0] out_data_b;
    logic        out_valid_b;
    logic        ll_b;
    logic        last_b;
    logic        busy_b;
    logic        done_b;

    matrix_stream_writer #(.ROWS(2), .COLS(3), .DW(32), .RD_LAT(1)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .col_major(cm_a),
        .rd_en(rd_en_a), .rd_row(rd_row_a), .rd_col(rd_col_a),
        .rd_data(rd_data_a), .out_data(out_data_a),
        .out_valid(out_valid_a), .out_ready(out_ready_a),
        .out_last_line(ll_a), .out_last(last_a),
        .busy(busy_a), .done(done_a)
    );

    matrix_stream_writer #(.ROWS(1), .COLS(1), .DW(32), .RD_LAT(3)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .col_major(1'b0),
        .rd_en(rd_en_b), .rd_row(rd_row_b), .rd_col(rd_col_b),
        .rd_data(rd_data_b), .out_data(out_data_b),
        .out_valid(out_valid_b), .out_ready(1'b1),
        .out_last_line(ll_b), .out_last(last_b),
        .busy(busy_b), .done(done_b)
    );

    // Buffer A returns 10*r+c one cycle after rd_en, junk otherwise.
    always @(posedge clk) begin
        rd_data_a <= rd_en_a ? 32'(10 * int'(rd_row_a) + int'(rd_col_a))
                             : 32'hBAD0BAD0;
    end

    logic [31:0] pb1 = '0;
    logic [31:0] pb2 = '0;
    int done_cnt_a = 0;
    int rd_cnt_b = 0;
    always @(posedge clk) begin
        pb1       <= rd_en_b ? 32'hDEADBEEF : 32'h0;
        pb2       <= pb1;
        rd_data_b <= pb2;
        if (done_a) done_cnt_a <= done_cnt_a + 1;
        if (rd_en_b) rd_cnt_b <= rd_cnt_b + 1;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered at the READ sample; leaves one cycle after the handshake.
    task automatic elem(input int r, input int c, input logic ll,
                        input logic last, input int stall);
        logic [31:0] d;
        d = 32'(10 * r + c);
        chk("rd_en", 32'(rd_en_a), 32'd1);
        chk("rd_row", 32'(rd_row_a), 32'(r));
        chk("rd_col", 32'(rd_col_a), 32'(c));
        chk("valid_read", 32'(out_valid_a), 32'd0);
        tick();
        chk("rd_en_wait", 32'(rd_en_a), 32'd0);
        chk("valid_wait", 32'(out_valid_a), 32'd0);
        tick();
        chk("valid", 32'(out_valid_a), 32'd1);
        chk("data", out_data_a, d);
        chk("last_line", 32'(ll_a), 32'(ll));
        chk("last", 32'(last_a), 32'(last));
        chk("done_send", 32'(done_a), 32'd0);
        for (int i = 0; i < stall; i++) begin
            out_ready_a = 1'b0;
            tick();
            chk("stall_valid", 32'(out_valid_a), 32'd1);
            chk("stall_data", out_data_a, d);
            chk("stall_rd_en", 32'(rd_en_a), 32'd0);
        end
        out_ready_a = 1'b1;
        tick();
    endtask

    task automatic begin_xfer(input logic cm);
        start_a = 1'b1;
        cm_a = cm;
        tick();
        start_a = 1'b0;
    endtask

    task automatic finish_done();
        chk("done", 32'(done_a), 32'd1);
        chk("busy_done", 32'(busy_a), 32'd1);
        chk("valid_done", 32'(out_valid_a), 32'd0);
        tick();
        chk("done_clear", 32'(done_a), 32'd0);
        chk("busy_idle", 32'(busy_a), 32'd0);
    endtask

    int rm_r[6] = '{0, 0, 0, 1, 1, 1};
    int rm_c[6] = '{0, 1, 2, 0, 1, 2};
    logic rm_ll[6] = '{0, 0, 1, 0, 0, 1};
    int cm_r[6] = '{0, 1, 0, 1, 0, 1};
    int cm_c[6] = '{0, 0, 1, 1, 2, 2};
    logic cm_ll[6] = '{0, 1, 0, 1, 0, 1};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation timed out");
        $fatal(1);
    end

    initial begin
        int snap;
        tick();
        tick();
        chk("rst_valid_a", 32'(out_valid_a), 32'd0);
        chk("rst_busy_a", 32'(busy_a), 32'd0);
        chk("rst_rd_en_a", 32'(rd_en_a), 32'd0);
        chk("rst_data_a", out_data_a, 32'd0);
        chk("rst_done_a", 32'(done_a), 32'd0);
        chk("rst_busy_b", 32'(busy_b), 32'd0);
        rst_n = 1'b1;
        tick();

        // row-major
        begin_xfer(1'b0);
        for (int i = 0; i < 6; i++)
            elem(rm_r[i], rm_c[i], rm_ll[i], i == 5, 0);
        finish_done();

        // column-major
        begin_xfer(1'b1);
        for (int i = 0; i < 6; i++)
            elem(cm_r[i], cm_c[i], cm_ll[i], i == 5, 0);
        finish_done();

        // backpressure on the first element
        begin_xfer(1'b0);
        for (int i = 0; i < 6; i++)
            elem(rm_r[i], rm_c[i], rm_ll[i], i == 5, (i == 0) ? 5 : 0);
        finish_done();

        // start/col_major noise mid-transfer and in the DONE cycle
        snap = done_cnt_a;
        begin_xfer(1'b0);
        for (int i = 0; i < 6; i++) begin
            start_a = (i == 2);
            cm_a = (i == 2);
            elem(rm_r[i], rm_c[i], rm_ll[i], i == 5, 0);
        end
        start_a = 1'b1;
        chk("done_noise", 32'(done_a), 32'd1);
        tick();
        start_a = 1'b0;
        chk("idle_after_done_start", 32'(busy_a), 32'd0);
        tick();
        chk("no_restart_busy", 32'(busy_a), 32'd0);
        chk("no_restart_rd_en", 32'(rd_en_a), 32'd0);
        chk("done_count", 32'(done_cnt_a - snap), 32'd1);

        // reset while element 11 is stalled in SEND
        begin_xfer(1'b0);
        for (int i = 0; i < 4; i++)
            elem(rm_r[i], rm_c[i], rm_ll[i], 1'b0, 0);
        chk("rd_row_11", 32'(rd_row_a), 32'd1);
        chk("rd_col_11", 32'(rd_col_a), 32'd1);
        tick();
        tick();
        chk("data_11", out_data_a, 32'd11);
        out_ready_a = 1'b0;
        tick();
        chk("held_11", 32'(out_valid_a), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid_a), 32'd0);
        chk("arst_rd_en", 32'(rd_en_a), 32'd0);
        chk("arst_busy", 32'(busy_a), 32'd0);
        chk("arst_data", out_data_a, 32'd0);
        chk("arst_row", 32'(rd_row_a), 32'd0);
        chk("arst_col", 32'(rd_col_a), 32'd0);
        tick();
        chk("arst_done1", 32'(done_a), 32'd0);
        tick();
        chk("arst_done2", 32'(done_a), 32'd0);
        rst_n = 1'b1;
        out_ready_a = 1'b1;
        tick();
        begin_xfer(1'b0);
        for (int i = 0; i < 6; i++)
            elem(rm_r[i], rm_c[i], rm_ll[i], i == 5, 0);
        finish_done();

        // 1x1 matrix, read latency 3
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        chk("b_rd_en", 32'(rd_en_b), 32'd1);
        chk("b_rd_row", 32'(rd_row_b), 32'd0);
        chk("b_rd_col", 32'(rd_col_b), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("b_wait_rd_en", 32'(rd_en_b), 32'd0);
            chk("b_wait_valid", 32'(out_valid_b), 32'd0);
        end
        tick();
        chk("b_valid", 32'(out_valid_b), 32'd1);
        chk("b_data", out_data_b, 32'hDEADBEEF);
        chk("b_last_line", 32'(ll_b), 32'd1);
        chk("b_last", 32'(last_b), 32'd1);
        tick();
        chk("b_done", 32'(done_b), 32'd1);
        chk("b_valid_drop", 32'(out_valid_b), 32'd0);
        tick();
        chk("b_done_clear", 32'(done_b), 32'd0);
        chk("b_busy", 32'(busy_b), 32'd0);
        chk("b_rd_count", 32'(rd_cnt_b), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
